data_bus_ctrl: RTL
==================

Name: data_bus_ctrl

Overview:
- Downstream consumer of the single-cycle datapath's memory interface: takes ALUResult as address, plus WriteData and MemWrite; returns ReadData in the same cycle.
- Decodes the address into a word-addressed data RAM and a small memory-mapped I/O region.
- The I/O region holds an 8-bit output FIFO with a valid/ready handshake, a synchronised switch input register, and a writable free-running cycle counter.

Parameters:
- RAM_WORDS, 64, data RAM depth in 32-bit words; power of two.
- IO_BASE, 32'h0000_4000, base byte address of the I/O region.
- FIFO_DEPTH, 8, output FIFO entries; power of two, at least 2.
- SW_W, 10, switch input width.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- MemWrite  in  1  write strobe from control
- Adr  in  32  byte address (ALUResult)
- WriteData  in  32  store data
- ReadData  out  32  load data, combinational
- out_data  out  8  FIFO head byte
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts the head byte
- sw_in  in  SW_W  asynchronous switch inputs

Behaviour:
- Access model: word accesses only; Adr[1:0] ignored.
- RAM hit: Adr < RAM_WORDS*4. Read is asynchronous (RAM[Adr[..:2]]). Write on rising edge when MemWrite and hit.
- I/O hit: Adr[31:4] == IO_BASE[31:4].
- Unmapped addresses: read 0; writes ignored.
- I/O map (offsets from IO_BASE):
  - 0x0 TXDATA: write pushes WriteData[7:0] into the FIFO; read returns 0.
  - 0x4 STATUS: read gives {16'b0, count[7:0], 5'b0, ovf, empty, full}. Writing with WriteData[2]=1 clears ovf; other bits read-only.
  - 0x8 SWITCH: read returns the zero-extended 2-flop-synchronised sw_in; writes ignored.
  - 0xC CYCLES: read returns the counter. Write loads WriteData, and the load wins over that cycle's increment.
- Counter: +1 every cycle; wraps 32'hFFFF_FFFF -> 0.
- FIFO:
  - push = MemWrite & TXDATA hit; pop = out_valid & out_ready.
  - out_valid = !empty; out_data = head entry, stable while out_valid & !out_ready.
  - Push when full without a simultaneous pop: data dropped, ovf set (sticky), count unchanged.
  - Push and pop when full: both occur; count stays FIFO_DEPTH; ovf unchanged.
  - Push and pop when not empty and not full: count unchanged; order preserved.
  - Push when empty: out_valid rises the next cycle (no fall-through).
  - Pointers wrap modulo FIFO_DEPTH; count width is clog2(FIFO_DEPTH)+1.
- Reset (synchronous, including mid-transfer):
  - FIFO emptied, so out_valid=0 the cycle after reset is sampled; pointers, count and ovf = 0.
  - Counter = 0; sync flops = 0.
  - RAM contents are not reset.
  - Any push or write in a reset cycle is ignored.
- ReadData during reset reflects the current state combinationally; no reset value is required.

Decomposition:
- Shared package data_bus_pkg:
  - offset constants TXDATA_OFS, STATUS_OFS, SWITCH_OFS, CYCLES_OFS;
  - STATUS bit indices ST_FULL=0, ST_EMPTY=1, ST_OVF=2, ST_COUNT_LSB=8;
  - region-select enum {SEL_RAM, SEL_IO, SEL_NONE}.
- Sub-module sync_fifo (params WIDTH, DEPTH): push, pop, dout, full, empty, count. The ovf flag stays in the parent.
- Address decode and read mux stay inline.

Test Plan:
- RAM loopback: write 32'hDEAD_BEEF to 0x10 and 32'h1234_5678 to 0x14; read 0x10 then 0x13 -> both DEAD_BEEF; read 0x14 -> 1234_5678. Read 0x2000 -> 0.
- FIFO fill with out_ready=0:
  - push 0x41..0x48 -> STATUS=0x0000_0801 (count 8, full).
  - 9th push 0x49 -> STATUS=0x0000_0805 (ovf set).
  - write STATUS with 4 -> ovf cleared, STATUS back to 0x0000_0801.
- Drain with out_ready=1: out_data sequence 0x41..0x48, one per cycle; out_valid falls after 0x48; STATUS=0x0000_0002.
- Simultaneous push/pop at full: FIFO full, out_ready=1, push 0x5A in the same cycle -> count stays 8, ovf=0, 0x5A emerges 8th.
- Counter:
  - after reset, read CYCLES at cycle n -> n.
  - write 32'hFFFF_FFFE -> reads FFFF_FFFE, then FFFF_FFFF, then 0000_0000.
- Reset mid-operation: 3 bytes queued, assert reset 1 cycle -> out_valid=0, STATUS=0x0000_0002, CYCLES=0; a previously written RAM word reads unchanged. sw_in=10'h2A5 -> SWITCH reads 0x2A5 two cycles later.

Source files
------------

// File: rtl/data_bus_pkg.sv
// Shared constants for the data bus controller: I/O register offsets,
// STATUS bit positions and the address-region select type.
package data_bus_pkg;

   localparam logic [3:0] TXDATA_OFS = 4'h0;
   localparam logic [3:0] STATUS_OFS = 4'h4;
   localparam logic [3:0] SWITCH_OFS = 4'h8;
   localparam logic [3:0] CYCLES_OFS = 4'hC;

   localparam int ST_FULL      = 0;
   localparam int ST_EMPTY     = 1;
   localparam int ST_OVF       = 2;
   localparam int ST_COUNT_LSB = 8;

   typedef enum logic [1:0] {
      SEL_RAM,
      SEL_IO,
      SEL_NONE
   } sel_e;

endpackage

// File: rtl/data_bus_ctrl_sync_fifo.sv
// Synchronous FIFO with registered head output. Pushes while full are
// accepted only when a pop frees the slot in the same cycle.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);
   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;
   assign dout  = mem_q[rd_ptr_q];

   always_comb begin
      do_pop   = pop && !empty;
      do_push  = push && (!full || do_pop);
      wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = do_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
      count_d  = count_q + CW'(do_push) - CW'(do_pop);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // storage is not reset; reads of an empty FIFO are masked by empty
   always_ff @(posedge clk) begin
      if (do_push && !reset) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/data_bus_ctrl.sv
// Memory-side bus controller: word RAM plus an I/O page holding a TX FIFO,
// synchronised switches and a loadable free-running cycle counter.
module data_bus_ctrl
   import data_bus_pkg::*;
#(
   parameter int          RAM_WORDS  = 64,
   parameter logic [31:0] IO_BASE    = 32'h0000_4000,
   parameter int          FIFO_DEPTH = 8,
   parameter int          SW_W       = 10
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            MemWrite,
   input  logic [31:0]     Adr,
   input  logic [31:0]     WriteData,
   output logic [31:0]     ReadData,
   output logic [7:0]      out_data,
   output logic            out_valid,
   input  logic            out_ready,
   input  logic [SW_W-1:0] sw_in
);
   localparam int          RAM_AW    = $clog2(RAM_WORDS);
   localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);
   localparam int          CW        = $clog2(FIFO_DEPTH) + 1;

   logic [31:0]     ram_q [RAM_WORDS];
   logic [RAM_AW-1:0] ram_idx;
   sel_e            sel;
   logic [3:0]      io_ofs;
   logic            ram_we, push, pop, status_wr, cycles_wr;
   logic            full, empty;
   logic [CW-1:0]   count;
   logic [31:0]     status;
   logic            ovf_q, ovf_d;
   logic [31:0]     cyc_q, cyc_d;
   logic [SW_W-1:0] sw_meta_q, sw_sync_q;

   assign ram_idx = Adr[RAM_AW+1:2];
   assign io_ofs  = {Adr[3:2], 2'b00};

   always_comb begin
      sel = SEL_NONE;
      if (Adr < RAM_BYTES)                  sel = SEL_RAM;
      else if (Adr[31:4] == IO_BASE[31:4])  sel = SEL_IO;
   end

   always_comb begin
      ram_we    = MemWrite && (sel == SEL_RAM) && !reset;
      push      = MemWrite && (sel == SEL_IO) && (io_ofs == TXDATA_OFS);
      status_wr = MemWrite && (sel == SEL_IO) && (io_ofs == STATUS_OFS);
      cycles_wr = MemWrite && (sel == SEL_IO) && (io_ofs == CYCLES_OFS);
      pop       = out_valid && out_ready;
   end

   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH), .CW(CW)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   (WriteData[7:0]),
      .dout  (out_data),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   assign out_valid = !empty;

   always_comb begin
      ovf_d = ovf_q;
      if (status_wr && WriteData[ST_OVF]) ovf_d = 1'b0;
      if (push && full && !pop)           ovf_d = 1'b1;
      cyc_d = cycles_wr ? WriteData : cyc_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ovf_q     <= 1'b0;
         cyc_q     <= '0;
         sw_meta_q <= '0;
         sw_sync_q <= '0;
      end else begin
         ovf_q     <= ovf_d;
         cyc_q     <= cyc_d;
         sw_meta_q <= sw_in;
         sw_sync_q <= sw_meta_q;
      end
   end

   always_ff @(posedge clk) begin
      if (ram_we) ram_q[ram_idx] <= WriteData;
   end

   always_comb begin
      status                         = '0;
      status[ST_FULL]                = full;
      status[ST_EMPTY]               = empty;
      status[ST_OVF]                 = ovf_q;
      status[ST_COUNT_LSB +: CW]     = count;
   end

   always_comb begin
      ReadData = '0;
      case (sel)
         SEL_RAM: ReadData = ram_q[ram_idx];
         SEL_IO: begin
            case (io_ofs)
               STATUS_OFS: ReadData = status;
               SWITCH_OFS: ReadData = 32'(sw_sync_q);
               CYCLES_OFS: ReadData = cyc_q;
               default:    ReadData = '0;
            endcase
         end
         default: ReadData = '0;
      endcase
   end

endmodule
